gearbox_pack_arbiter: RTL

//   Packet-granular round-robin arbiter sharing one gearbox_packing datapath among N_SRC AXI-Stream sources.

---
 rtl/gearbox_pack_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/gearbox_pack_arbiter.sv
// rtl/gearbox_pack_arbiter.sv - packet-granular round-robin arbiter in front of gearbox_packing
//
// Purpose:
//   Shares one gearbox_packing input among N_SRC stream sources. A source wins
//   for a whole packet (up to MAX_BEATS beats). Its beats pass through a single
//   registered stage, tagged with the source id.
//
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   in_tdata/tkeep/tlast/tvalid per-source beats, source s at slice s
//   in_tready                   per-source ready, at most one bit set
//   out_tdata/tkeep/tlast/tid   registered beat towards the packer
//   out_tvalid/out_tready       output handshake
//   busy                        high while a packet grant is held
//   err_trunc                   one-cycle pulse when a packet is cut at MAX_BEATS
module gearbox_pack_arbiter #(
   parameter int N_SRC     = 4,
   parameter int n         = 10,
   parameter int MAX_BEATS = 64
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [N_SRC*n*8-1:0]     in_tdata,
   input  logic [N_SRC*n-1:0]       in_tkeep,
   input  logic [N_SRC-1:0]         in_tlast,
   input  logic [N_SRC-1:0]         in_tvalid,
   output logic [N_SRC-1:0]         in_tready,
   output logic [n*8-1:0]           out_tdata,
   output logic [n-1:0]             out_tkeep,
   output logic                     out_tlast,
   output logic [$clog2(N_SRC)-1:0] out_tid,
   output logic                     out_tvalid,
   input  logic                     out_tready,
   output logic                     busy,
   output logic                     err_trunc
);

   localparam int NB = n * 8;
   localparam int IW = $clog2(N_SRC);
   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BEATS - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IW-1:0]   r_gnt;
   logic [IW-1:0]   w_gnt_nxt;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   w_rr_ptr_nxt;
   logic [IW-1:0]   w_rr_inc;
   logic [CW-1:0]   r_beat_cnt;
   logic [CW-1:0]   w_beat_cnt_nxt;

   logic [NB-1:0]   r_out_tdata;
   logic [n-1:0]    r_out_tkeep;
   logic            r_out_tlast;
   logic [IW-1:0]   r_out_tid;
   logic            r_out_tvalid;
   logic            r_err_trunc;

   logic            w_found;
   logic [IW-1:0]   w_pick;
   logic [IW:0]     w_sum;
   logic [IW-1:0]   w_idx;

   logic [NB-1:0]   w_sel_data;
   logic [n-1:0]    w_sel_keep;
   logic            w_sel_last;
   logic            w_sel_valid;

   logic            w_slot_free;
   logic            w_accept;
   logic            w_at_limit;
   logic            w_end;
   logic            w_fwd;
   logic            w_trunc;

   // Rotating search starting at rr_ptr; first valid source wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr_ptr;
      w_sum   = '0;
      w_idx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
         if (w_sum >= (IW+1)'(N_SRC)) begin
            w_sum = w_sum - (IW+1)'(N_SRC);
         end
         w_idx = w_sum[IW-1:0];
         if (!w_found && in_tvalid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // Select the granted source's beat.
   always_comb begin
      w_sel_data  = '0;
      w_sel_keep  = '0;
      w_sel_last  = 1'b0;
      w_sel_valid = 1'b0;
      for (int s = 0; s < N_SRC; s++) begin
         if (r_gnt == IW'(s)) begin
            w_sel_data  = in_tdata[s*NB +: NB];
            w_sel_keep  = in_tkeep[s*n +: n];
            w_sel_last  = in_tlast[s];
            w_sel_valid = in_tvalid[s];
         end
      end
   end

   // The output register can take a beat if empty or draining this cycle.
   assign w_slot_free = ~r_out_tvalid | out_tready;

   always_comb begin
      in_tready = '0;
      if (r_state == S_GRANT) begin
         for (int s = 0; s < N_SRC; s++) begin
            if (r_gnt == IW'(s)) begin
               in_tready[s] = w_slot_free;
            end
         end
      end
   end

   assign w_accept   = (r_state == S_GRANT) & w_sel_valid & w_slot_free;
   assign w_at_limit = (r_beat_cnt == LAST_CNT);
   assign w_trunc    = w_accept & ~w_sel_last & w_at_limit;
   assign w_end      = w_accept & (w_sel_last | w_at_limit);
   // Empty non-final beats are swallowed; the closing beat always goes out
   // so the packer still sees the packet boundary.
   assign w_fwd      = w_accept & ((|w_sel_keep) | w_sel_last | w_at_limit);
   assign w_rr_inc   = (r_gnt == IW'(N_SRC - 1)) ? '0 : r_gnt + IW'(1);

   always_comb begin
      w_state_nxt    = r_state;
      w_gnt_nxt      = r_gnt;
      w_rr_ptr_nxt   = r_rr_ptr;
      w_beat_cnt_nxt = r_beat_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt    = S_GRANT;
               w_gnt_nxt      = w_pick;
               w_beat_cnt_nxt = '0;
            end
         end
         S_GRANT: begin
            if (w_end) begin
               w_state_nxt    = S_IDLE;
               w_rr_ptr_nxt   = w_rr_inc;
               w_beat_cnt_nxt = '0;
            end else if (w_accept) begin
               w_beat_cnt_nxt = r_beat_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_out_tdata  <= '0;
         r_out_tkeep  <= '0;
         r_out_tlast  <= 1'b0;
         r_out_tid    <= '0;
         r_out_tvalid <= 1'b0;
         r_err_trunc  <= 1'b0;
      end else begin
         r_err_trunc <= w_trunc;
         if (w_fwd) begin
            r_out_tvalid <= 1'b1;
            r_out_tdata  <= w_sel_data;
            r_out_tkeep  <= w_sel_keep;
            r_out_tlast  <= w_sel_last | w_at_limit;
            r_out_tid    <= r_gnt;
         end else if (out_tready) begin
            r_out_tvalid <= 1'b0;
         end
      end
   end

   assign out_tdata  = r_out_tdata;
   assign out_tkeep  = r_out_tkeep;
   assign out_tlast  = r_out_tlast;
   assign out_tid    = r_out_tid;
   assign out_tvalid = r_out_tvalid;
   assign err_trunc  = r_err_trunc;
   assign busy       = (r_state == S_GRANT);

endmodule
